// File: rtl/sid_pkg.sv
// Shared constants and types for the SID register write path.
package sid_pkg;

  localparam int SID_ADDR_W = 5;
  localparam int SID_DATA_W = 8;
  localparam int SID_DELAY_W = 16;
  localparam logic [SID_ADDR_W-1:0] SID_LAST_WR_ADDR = 5'h18;
  localparam int SID_NUM_WR_REGS = 25;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE
  } sid_state_e;

  typedef struct packed {
    logic [SID_DELAY_W-1:0] delay;
    logic [SID_ADDR_W-1:0]  addr;
    logic [SID_DATA_W-1:0]  data;
  } sid_wr_entry_t;

  // Addresses above the last writable register are read-only or unused on the SID.
  function automatic logic sid_addr_writable(input logic [SID_ADDR_W-1:0] addr);
    return addr <= SID_LAST_WR_ADDR;
  endfunction

endpackage

// File: rtl/sid_reg_writer_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output and synchronous flush.
module sid_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush discards everything, including a same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (!do_push && do_pop) level <= level - LVL_W'(1);
    end
  end

  // Storage is written only on an accepted push; stale slots are harmless after a flush.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sid_reg_writer.sv
// Timestamped SID register write scheduler with a readable shadow of the write-only registers.
import sid_pkg::*;

module sid_reg_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DELAY_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clkEn,
  input  logic                        iValid,
  output logic                        oReady,
  input  logic [DELAY_W-1:0]          iDelay,
  input  logic [SID_ADDR_W-1:0]       iAddr,
  input  logic [SID_DATA_W-1:0]       iData,
  input  logic                        iPause,
  input  logic                        iFlush,
  output logic [$clog2(FIFO_DEPTH):0] oLevel,
  output logic                        oWE,
  output logic [SID_ADDR_W-1:0]       oAddr,
  output logic [SID_DATA_W-1:0]       oData,
  output logic                        oDrop,
  input  logic [SID_ADDR_W-1:0]       iRdAddr,
  output logic [SID_DATA_W-1:0]       oRdData
);

  localparam int ENTRY_W = DELAY_W + SID_ADDR_W + SID_DATA_W;

  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DELAY_W-1:0]    head_delay;
  logic [SID_ADDR_W-1:0] head_addr;
  logic [SID_DATA_W-1:0] head_data;

  sid_state_e            state;
  logic [DELAY_W-1:0]    count;
  logic [SID_ADDR_W-1:0] hold_addr;
  logic [SID_DATA_W-1:0] hold_data;
  logic                  launch;
  logic [SID_ADDR_W-1:0] launch_addr;
  logic [SID_DATA_W-1:0] launch_data;
  logic [SID_DATA_W-1:0] shadow [SID_NUM_WR_REGS];

  assign oReady     = !fifo_full && !iFlush;
  assign push       = iValid && oReady;
  assign pop        = (state == IDLE) && !fifo_empty && !iPause && !iFlush;
  assign fifo_wdata = {iDelay, iAddr, iData};
  assign {head_delay, head_addr, head_data} = fifo_rdata;

  sid_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (iFlush),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (oLevel)
  );

  // Decide whether the next edge issues an entry: a zero-delay pop goes straight out, otherwise the last countdown tick.
  always_comb begin
    launch      = 1'b0;
    launch_addr = hold_addr;
    launch_data = hold_data;
    if (pop && (head_delay == '0)) begin
      launch      = 1'b1;
      launch_addr = head_addr;
      launch_data = head_data;
    end else if ((state == WAIT) && clkEn && !iPause && (count == DELAY_W'(1))) begin
      launch = 1'b1;
    end
  end

  // Scheduler FSM with registered strobe, address, data and drop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      oWE       <= 1'b0;
      oAddr     <= '0;
      oData     <= '0;
      oDrop     <= 1'b0;
    end else if (iFlush) begin
      state <= IDLE;
      count <= '0;
      oWE   <= 1'b0;
      oDrop <= 1'b0;
    end else begin
      oWE   <= 1'b0;
      oDrop <= 1'b0;
      if (launch) begin
        state <= WRITE;
        if (sid_addr_writable(launch_addr)) begin
          oWE   <= 1'b1;
          oAddr <= launch_addr;
          oData <= launch_data;
        end else begin
          oDrop <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              hold_addr <= head_addr;
              hold_data <= head_data;
              count     <= head_delay;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (clkEn && !iPause) count <= count - DELAY_W'(1);
          end
          WRITE:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Shadow capture on the edge that closes a real strobe, and registered readback (old value on a same-cycle hit).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SID_NUM_WR_REGS; i++) shadow[i] <= '0;
      oRdData <= '0;
    end else begin
      if ((state == WRITE) && oWE && !iFlush) shadow[oAddr] <= oData;
      oRdData <= sid_addr_writable(iRdAddr) ? shadow[iRdAddr] : '0;
    end
  end

endmodule

// File: tb/tb_sid_reg_writer.sv
// Self-checking bench for sid_reg_writer: directed timing scenarios plus a randomized ordering/shadow run.
module tb_sid_reg_writer;

  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clkEn = 1'b0;
  logic          iValid = 1'b0;
  logic          iPause = 1'b0;
  logic          iFlush = 1'b0;
  logic [DW-1:0] iDelay = '0;
  logic [4:0]    iAddr = '0;
  logic [7:0]    iData = '0;
  logic [4:0]    iRdAddr = '0;
  logic          oReady;
  logic          oWE;
  logic          oDrop;
  logic [4:0]    oAddr;
  logic [7:0]    oData;
  logic [7:0]    oRdData;
  logic [4:0]    oLevel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_mode = 0;
  int drop_cnt = 0;
  int drop_cyc = -1;
  logic [4:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  logic [7:0] shadow_m [32];

  sid_reg_writer #(.FIFO_DEPTH(DEPTH), .DELAY_W(DW)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iValid(iValid), .oReady(oReady),
    .iDelay(iDelay), .iAddr(iAddr), .iData(iData), .iPause(iPause), .iFlush(iFlush),
    .oLevel(oLevel), .oWE(oWE), .oAddr(oAddr), .oData(oData), .oDrop(oDrop),
    .iRdAddr(iRdAddr), .oRdData(oRdData)
  );

  always #5 clk = ~clk;

  // Edge counter: after an edge settles, cyc is that edge's number.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and drop logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (oWE) begin
      wr_addr_q.push_back(oAddr);
      wr_data_q.push_back(oData);
      wr_cyc_q.push_back(cyc);
    end
    if (oDrop) begin
      drop_cnt = drop_cnt + 1;
      drop_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ce_mode)
      0:       clkEn = 1'b1;
      1:       clkEn = (cyc % 4 == 0);
      default: clkEn = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    drop_cnt = 0;
    drop_cyc = -1;
  endtask

  // Presents one entry until accepted; k returns the accepting edge number.
  task automatic push_entry(input logic [DW-1:0] d, input logic [4:0] a, input logic [7:0] v, output int k);
    int guard = 0;
    while (!oReady && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (!oReady) begin errors++; $display("[TB] FAIL push_ready got %0b want 1", oReady); end
    iValid = 1'b1; iDelay = d; iAddr = a; iData = v;
    step();
    k = cyc;
    iValid = 1'b0;
  endtask

  task automatic read_shadow(input logic [4:0] a, output logic [7:0] v);
    iRdAddr = a;
    step();
    v = oRdData;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (oWE !== 1'b0)    begin errors++; $display("[TB] FAIL reset_oWE got %0b want 0", oWE); end
    checks++; if (oAddr !== 5'h0)  begin errors++; $display("[TB] FAIL reset_oAddr got %0h want 0", oAddr); end
    checks++; if (oData !== 8'h0)  begin errors++; $display("[TB] FAIL reset_oData got %0h want 0", oData); end
    checks++; if (oDrop !== 1'b0)  begin errors++; $display("[TB] FAIL reset_oDrop got %0b want 0", oDrop); end
    checks++; if (oLevel !== 5'd0) begin errors++; $display("[TB] FAIL reset_oLevel got %0d want 0", oLevel); end
    checks++; if (oRdData !== 8'h0) begin errors++; $display("[TB] FAIL reset_oRdData got %0h want 0", oRdData); end
    rst = 1'b0;
    step();
    checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_oReady got %0b want 1", oReady); end
  endtask

  task automatic test_basic();
    int k;
    logic [7:0] v;
    clear_logs(); ce_mode = 0;
    push_entry(16'd0, 5'h15, 8'h07, k);
    repeat (6) step();
    checks++; if (wr_addr_q.size() != 1) begin errors++; $display("[TB] FAIL basic_count got %0d want 1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      checks++; if (wr_cyc_q[0] != k + 1) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", wr_cyc_q[0], k + 1); end
      checks++; if (wr_addr_q[0] !== 5'h15) begin errors++; $display("[TB] FAIL basic_addr got %0h want 15", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== 8'h07) begin errors++; $display("[TB] FAIL basic_data got %0h want 07", wr_data_q[0]); end
    end
    shadow_m[5'h15] = 8'h07;
    read_shadow(5'h15, v);
    checks++; if (v !== 8'h07) begin errors++; $display("[TB] FAIL basic_readback got %0h want 07", v); end
  endtask

  // clkEn is sampled high at edges e with e%4==1; the strobe edge is the 3rd (4th when one is paused) such edge after the pop.
  task automatic test_delay(input bit with_pause);
    int k, p, e, exp_cyc;
    clear_logs(); ce_mode = 1;
    push_entry(16'd3, 5'h16, 8'hA5, k);
    p = k + 1;
    step();
    if (with_pause) begin
      iPause = 1'b1;
      repeat (4) step();
      iPause = 1'b0;
    end
    repeat (30) step();
    e = p + 1;
    while (e % 4 != 1) e++;
    exp_cyc = e + 4 * (with_pause ? 3 : 2);
    checks++; if (wr_addr_q.size() != 1) begin errors++; $display("[TB] FAIL delay%0d_count got %0d want 1", with_pause, wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      checks++; if (wr_cyc_q[0] != exp_cyc) begin errors++; $display("[TB] FAIL delay%0d_edge got %0d want %0d", with_pause, wr_cyc_q[0], exp_cyc); end
      checks++; if (wr_data_q[0] !== 8'hA5 || wr_addr_q[0] !== 5'h16) begin errors++; $display("[TB] FAIL delay%0d_entry got %0h/%0h want 16/a5", with_pause, wr_addr_q[0], wr_data_q[0]); end
    end
    shadow_m[5'h16] = 8'hA5;
    ce_mode = 0;
  endtask

  task automatic test_full();
    int k;
    logic [4:0] a [16];
    logic [7:0] d [16];
    clear_logs(); ce_mode = 0; iPause = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a[i] = 5'($urandom_range(0, 24));
      d[i] = 8'($urandom);
      push_entry(16'd0, a[i], d[i], k);
    end
    checks++; if (oLevel !== 5'd16) begin errors++; $display("[TB] FAIL full_level got %0d want 16", oLevel); end
    checks++; if (oReady !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %0b want 0", oReady); end
    iValid = 1'b1; iDelay = '0; iAddr = 5'h01; iData = 8'hEE;
    step(); step();
    iValid = 1'b0;
    checks++; if (oLevel !== 5'd16) begin errors++; $display("[TB] FAIL full_17th got %0d want 16", oLevel); end
    iPause = 1'b0;
    repeat (40) step();
    checks++; if (wr_addr_q.size() != 16) begin errors++; $display("[TB] FAIL full_count got %0d want 16", wr_addr_q.size()); end
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== a[i] || wr_data_q[i] !== d[i]) begin
        errors++; $display("[TB] FAIL full_order[%0d] got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], a[i], d[i]);
      end
      if (i > 0) begin
        checks++;
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != 2) begin errors++; $display("[TB] FAIL full_spacing[%0d] got %0d want 2", i, wr_cyc_q[i] - wr_cyc_q[i-1]); end
      end
      shadow_m[a[i]] = d[i];
    end
  endtask

  task automatic test_drop();
    int k;
    logic [7:0] v;
    clear_logs(); ce_mode = 0;
    push_entry(16'd0, 5'h1B, 8'hFF, k);
    repeat (5) step();
    checks++; if (drop_cnt != 1) begin errors++; $display("[TB] FAIL drop_count got %0d want 1", drop_cnt); end
    checks++; if (drop_cyc != k + 1) begin errors++; $display("[TB] FAIL drop_edge got %0d want %0d", drop_cyc, k + 1); end
    checks++; if (wr_addr_q.size() != 0) begin errors++; $display("[TB] FAIL drop_nowe got %0d want 0", wr_addr_q.size()); end
    read_shadow(5'h1B, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL drop_read1b got %0h want 0", v); end
    read_shadow(5'h16, v);
    checks++; if (v !== shadow_m[5'h16]) begin errors++; $display("[TB] FAIL drop_shadow got %0h want %0h", v, shadow_m[5'h16]); end
  endtask

  task automatic test_flush();
    int k;
    logic [7:0] v;
    clear_logs(); ce_mode = 0;
    push_entry(16'd100, 5'h01, 8'h11, k);
    push_entry(16'd0, 5'h02, 8'h22, k);
    push_entry(16'd0, 5'h03, 8'h33, k);
    repeat (10) step();
    checks++; if (oLevel !== 5'd2) begin errors++; $display("[TB] FAIL flush_prelevel got %0d want 2", oLevel); end
    iFlush = 1'b1; iValid = 1'b1; iDelay = '0; iAddr = 5'h04; iData = 8'h44;
    step();
    iFlush = 1'b0; iValid = 1'b0;
    checks++; if (oLevel !== 5'd0) begin errors++; $display("[TB] FAIL flush_level got %0d want 0", oLevel); end
    repeat (150) step();
    checks++; if (wr_addr_q.size() != 0 || drop_cnt != 0) begin errors++; $display("[TB] FAIL flush_quiet got %0d writes %0d drops want 0", wr_addr_q.size(), drop_cnt); end
    read_shadow(5'h15, v);
    checks++; if (v !== shadow_m[5'h15]) begin errors++; $display("[TB] FAIL flush_shadow got %0h want %0h", v, shadow_m[5'h15]); end
  endtask

  task automatic test_random();
    int n, k, budget, exp_drops;
    logic [4:0] a;
    logic [7:0] d, v;
    logic [DW-1:0] dl;
    logic [4:0] ea[$];
    logic [7:0] ed[$];
    clear_logs(); ce_mode = 2; exp_drops = 0; n = 30;
    for (int i = 0; i < n; i++) begin
      a  = 5'($urandom_range(0, 31));
      d  = 8'($urandom);
      dl = DW'($urandom_range(0, 5));
      iPause = (oLevel < 5'd12) && ($urandom_range(0, 3) == 0);
      push_entry(dl, a, d, k);
      if (a <= 5'h18) begin ea.push_back(a); ed.push_back(d); shadow_m[a] = d; end
      else exp_drops++;
    end
    iPause = 1'b0;
    budget = 0;
    while ((wr_addr_q.size() + drop_cnt) < n && budget < 3000) begin step(); budget++; end
    repeat (4) step();
    checks++; if (wr_addr_q.size() + drop_cnt != n) begin errors++; $display("[TB] FAIL rand_drain got %0d want %0d", wr_addr_q.size() + drop_cnt, n); end
    checks++; if (drop_cnt != exp_drops) begin errors++; $display("[TB] FAIL rand_drops got %0d want %0d", drop_cnt, exp_drops); end
    checks++; if (wr_addr_q.size() != ea.size()) begin errors++; $display("[TB] FAIL rand_writes got %0d want %0d", wr_addr_q.size(), ea.size()); end
    for (int i = 0; i < ea.size() && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
        errors++; $display("[TB] FAIL rand_order[%0d] got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
      end
    end
    ce_mode = 0;
    for (int i = 0; i < 32; i++) begin
      read_shadow(5'(i), v);
      checks++;
      if (v !== shadow_m[i]) begin errors++; $display("[TB] FAIL rand_shadow[%0h] got %0h want %0h", i, v, shadow_m[i]); end
    end
  endtask

  task automatic test_rst_mid();
    int k;
    logic [7:0] v;
    clear_logs(); ce_mode = 0;
    push_entry(16'd0, 5'h17, 8'hF1, k);
    repeat (4) step();
    shadow_m[5'h17] = 8'hF1;
    read_shadow(5'h17, v);
    checks++; if (v !== 8'hF1) begin errors++; $display("[TB] FAIL rstmid_pre got %0h want f1", v); end
    push_entry(16'd50, 5'h17, 8'h33, k);
    push_entry(16'd0, 5'h02, 8'h5A, k);
    repeat (10) step();
    clear_logs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) shadow_m[i] = 8'h00;
    checks++; if (oWE !== 1'b0 || oDrop !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_strobes got %0b/%0b want 0/0", oWE, oDrop); end
    checks++; if (oAddr !== 5'h0 || oData !== 8'h0) begin errors++; $display("[TB] FAIL rstmid_bus got %0h/%0h want 0/0", oAddr, oData); end
    checks++; if (oLevel !== 5'd0 || oRdData !== 8'h0) begin errors++; $display("[TB] FAIL rstmid_level got %0d/%0h want 0/0", oLevel, oRdData); end
    read_shadow(5'h17, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_shadow got %0h want 0", v); end
    repeat (80) step();
    checks++; if (wr_addr_q.size() != 0 || drop_cnt != 0) begin errors++; $display("[TB] FAIL rstmid_quiet got %0d writes %0d drops want 0", wr_addr_q.size(), drop_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow_m[i] = 8'h00;
    $display("[TB] starting sid_reg_writer bench");
    test_reset();
    test_basic();
    test_delay(1'b0);
    test_delay(1'b1);
    test_full();
    test_drop();
    test_flush();
    test_random();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
